// File: rtl/vga_pkg.sv
// Shared VGA types and default screen geometry used by the frame-buffer writers.
package vga_pkg;

    typedef enum logic [1:0] {
        WHITE = 2'd0,
        BLACK = 2'd1,
        BLUE  = 2'd2,
        RED   = 2'd3
    } color_t;

    localparam int HD_DEF = 1280;
    localparam int VD_DEF = 1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/vga_rect_fill.sv
// Command-driven rectangle/clear-screen pixel writer: one registered frame-buffer
// write per clock in raster order over the normalised, clamped region.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter int HD     = HD_DEF,
    parameter int VD     = VD_DEF,
    parameter int X_BITS = 11,
    parameter int Y_BITS = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_clear_i,
    input  logic [X_BITS-1:0] cmd_x0_i,
    input  logic [Y_BITS-1:0] cmd_y0_i,
    input  logic [X_BITS-1:0] cmd_x1_i,
    input  logic [Y_BITS-1:0] cmd_y1_i,
    input  color_t            cmd_color_i,
    output logic [X_BITS-1:0] addr_x_o,
    output logic [Y_BITS-1:0] addr_y_o,
    output color_t            color_o,
    output logic              we_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(HD - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(VD - 1);

    function automatic logic [X_BITS-1:0] clamp_x(input logic [X_BITS-1:0] v);
        if (v > X_MAX) begin
            return X_MAX;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [Y_BITS-1:0] clamp_y(input logic [Y_BITS-1:0] v);
        if (v > Y_MAX) begin
            return Y_MAX;
        end else begin
            return v;
        end
    endfunction

    fill_state_t       state_r, state_s;
    logic [X_BITS-1:0] xl_r, xl_s, xh_r, xh_s, x_r, x_s;
    logic [Y_BITS-1:0] yh_r, yh_s, y_r, y_s;
    color_t            color_r, color_s;
    logic              we_r, we_s, busy_r, busy_s, done_r, done_s, ready_r, ready_s;

    logic [X_BITS-1:0] lo_x_s, hi_x_s;
    logic [Y_BITS-1:0] lo_y_s, hi_y_s;

    // Bounds of the command currently on the inputs, normalised then clamped on screen.
    always_comb begin
        if (cmd_clear_i) begin
            lo_x_s = {X_BITS{1'b0}};
            hi_x_s = X_MAX;
            lo_y_s = {Y_BITS{1'b0}};
            hi_y_s = Y_MAX;
        end else begin
            lo_x_s = clamp_x((cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i);
            hi_x_s = clamp_x((cmd_x0_i < cmd_x1_i) ? cmd_x1_i : cmd_x0_i);
            lo_y_s = clamp_y((cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i);
            hi_y_s = clamp_y((cmd_y0_i < cmd_y1_i) ? cmd_y1_i : cmd_y0_i);
        end
    end

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        state_s = state_r;
        xl_s    = xl_r;
        xh_s    = xh_r;
        yh_s    = yh_r;
        x_s     = x_r;
        y_s     = y_r;
        color_s = color_r;
        we_s    = we_r;
        busy_s  = busy_r;
        done_s  = done_r;
        ready_s = ready_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i && ready_r) begin
                    state_s = ST_FILL;
                    xl_s    = lo_x_s;
                    xh_s    = hi_x_s;
                    yh_s    = hi_y_s;
                    x_s     = lo_x_s;
                    y_s     = lo_y_s;
                    color_s = cmd_color_i;
                    we_s    = 1'b1;
                    busy_s  = 1'b1;
                    ready_s = 1'b0;
                    done_s  = (lo_x_s == hi_x_s) && (lo_y_s == hi_y_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (done_r) begin
                    state_s = ST_IDLE;
                    x_s     = {X_BITS{1'b0}};
                    y_s     = {Y_BITS{1'b0}};
                    color_s = WHITE;
                    we_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    ready_s = 1'b1;
                end else begin
                    // Raster step: wrap to the left edge at the right bound.
                    if (x_r == xh_r) begin
                        x_s = xl_r;
                        y_s = y_r + 1'b1;
                    end else begin
                        x_s = x_r + 1'b1;
                        y_s = y_r;
                    end
                    done_s = (x_s == xh_r) && (y_s == yh_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                x_s     = {X_BITS{1'b0}};
                y_s     = {Y_BITS{1'b0}};
                color_s = WHITE;
                we_s    = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, bound and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            xl_r    <= {X_BITS{1'b0}};
            xh_r    <= {X_BITS{1'b0}};
            yh_r    <= {Y_BITS{1'b0}};
            x_r     <= {X_BITS{1'b0}};
            y_r     <= {Y_BITS{1'b0}};
            color_r <= WHITE;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            xl_r    <= xl_s;
            xh_r    <= xh_s;
            yh_r    <= yh_s;
            x_r     <= x_s;
            y_r     <= y_s;
            color_r <= color_s;
            we_r    <= we_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign cmd_ready_o = ready_r;
    assign addr_x_o    = x_r;
    assign addr_y_o    = y_r;
    assign color_o     = color_r;
    assign we_o        = we_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule
